// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared constants for the memory-access stage.
// funct3 codes, FSM states, Wishbone byte-lane masks, access checks.
package stage_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  localparam logic [3:0] SEL_B = 4'b0001;
  localparam logic [3:0] SEL_H = 4'b0011;
  localparam logic [3:0] SEL_W = 4'b1111;

  // Width codes the bus can actually perform.
  function automatic logic f3_ok(
    input logic       ld,
    input logic [2:0] f3
  );
    if (ld)
      return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    return f3 <= F3_SW;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic mis_chk(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic r;
    r = 1'b0;
    if (f3[1:0] == F3_LH[1:0])
      r = a[0];
    else if (f3[1:0] == F3_LW[1:0])
      r = (a != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/stage_mem_load_align.sv
// mem_load_align: picks and extends the addressed byte/half/word
// Ports: i_dat (bus word), i_funct3, i_addr (low addr bits) -> o_dat.
module mem_load_align
  import stage_mem_pkg::*;
(
  input  logic [31:0] i_dat,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  output logic [31:0] o_dat
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_dat[7:0];
    unique case (i_addr)
      2'd0: w_b = i_dat[7:0];
      2'd1: w_b = i_dat[15:8];
      2'd2: w_b = i_dat[23:16];
      2'd3: w_b = i_dat[31:24];
    endcase
    w_h = i_addr[1] ? i_dat[31:16] : i_dat[15:0];
    o_dat = '0;
    unique case (i_funct3)
      F3_LB:   o_dat = {{24{w_b[7]}}, w_b};
      F3_LBU:  o_dat = {24'd0, w_b};
      F3_LH:   o_dat = {{16{w_h[15]}}, w_h};
      F3_LHU:  o_dat = {16'd0, w_h};
      F3_LW:   o_dat = i_dat;
      default: o_dat = '0;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access stage, Wishbone-classic data master.
// In: execute bundle, flush, dwbm_dat_i/ack_i. Out: stall_o, write-back
// bundle, dwbm_* master. MEM_BUS_TIMEOUT_EN adds a bus watchdog.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_ld_mem_i,
  input  logic        is_st_mem_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_bus_fault_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i
);

  state_t      r_state;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_wdat;
  logic [31:0] r_waddr;
  logic [31:0] r_h_pc;
  logic [31:0] r_h_ins;
  logic [31:0] r_h_alu;
  logic [2:0]  r_h_f3;
  logic        r_h_ld;
  logic        r_kill;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [31:0] r_alu;
  logic [31:0] r_memd;
  logic [31:0] r_maddr;
  logic        r_ill;
  logic        r_iam;
  logic        r_ldm;
  logic        r_stm;
  logic        r_bf;

  logic        w_acc;
  logic        w_mem;
  logic        w_ok;
  logic        w_mis;
  logic        w_exc;
  logic        w_go;
  logic        w_bus;
  logic        w_to;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat;
  logic [31:0] w_ldat;

  assign w_bus = (r_state == ST_BUS);
  assign w_acc = valid_i && !w_bus;
  assign w_mem = is_ld_mem_i | is_st_mem_i;
  assign w_ok  = f3_ok(is_ld_mem_i, funct3_i);
  assign w_mis = w_ok && mis_chk(funct3_i, alu_d_i[1:0]);
  assign w_exc = e_illegal_inst_i | e_inst_addr_mis_i;
  assign w_go  = w_mem && w_ok && !w_mis && !w_exc && !flush_i;

  always_comb begin
    w_sel  = SEL_W;
    w_wdat = st_data_i;
    unique case (funct3_i[1:0])
      F3_SB[1:0]: begin
        w_sel  = SEL_B << alu_d_i[1:0];
        w_wdat = {4{st_data_i[7:0]}};
      end
      F3_SH[1:0]: begin
        w_sel  = SEL_H << alu_d_i[1:0];
        w_wdat = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align u_align (
    .i_dat    (dwbm_dat_i),
    .i_funct3 (r_h_f3),
    .i_addr   (r_h_alu[1:0]),
    .o_dat    (w_ldat)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;

  // r_cnt+1 is the number of BUS cycles seen including the current one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_cnt <= '0;
    else if (w_acc && w_go)
      r_cnt <= '0;
    else if (w_bus && !dwbm_ack_i)
      r_cnt <= r_cnt + 1'b1;
  end

  assign w_to = w_bus && !dwbm_ack_i && (r_cnt == TO_M1);
`else
  // Watchdog compiled out: constant 0, the bus waits for ack forever.
  assign w_to = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_waddr <= '0;
      r_h_pc  <= '0;
      r_h_ins <= '0;
      r_h_alu <= '0;
      r_h_f3  <= '0;
      r_h_ld  <= 1'b0;
      r_kill  <= 1'b0;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ins   <= '0;
      r_alu   <= '0;
      r_memd  <= '0;
      r_maddr <= '0;
      r_ill   <= 1'b0;
      r_iam   <= 1'b0;
      r_ldm   <= 1'b0;
      r_stm   <= 1'b0;
      r_bf    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc && w_go) begin
            r_state <= ST_BUS;
            r_cyc   <= 1'b1;
            r_we    <= is_st_mem_i;
            r_sel   <= w_sel;
            r_wdat  <= w_wdat;
            r_waddr <= {alu_d_i[31:2], 2'b00};
            r_h_pc  <= pc_i;
            r_h_ins <= instruction_i;
            r_h_alu <= alu_d_i;
            r_h_f3  <= funct3_i;
            r_h_ld  <= is_ld_mem_i;
            r_kill  <= 1'b0;
          end else if (w_acc) begin
            r_valid <= !flush_i;
            r_pc    <= pc_i;
            r_ins   <= instruction_i;
            r_alu   <= alu_d_i;
            r_memd  <= '0;
            r_maddr <= alu_d_i;
            r_ill   <= e_illegal_inst_i;
            r_iam   <= e_inst_addr_mis_i;
            r_ldm   <= is_ld_mem_i && w_mis;
            r_stm   <= is_st_mem_i && w_mis;
            r_bf    <= 1'b0;
          end
        end
        ST_BUS: begin
          if (flush_i)
            r_kill <= 1'b1;
          // ack beats the watchdog when both land in one cycle
          if (dwbm_ack_i || w_to) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_valid <= !(r_kill || flush_i);
            r_pc    <= r_h_pc;
            r_ins   <= r_h_ins;
            r_alu   <= r_h_alu;
            r_memd  <= (dwbm_ack_i && r_h_ld) ? w_ldat : '0;
            r_maddr <= r_h_alu;
            r_ill   <= 1'b0;
            r_iam   <= 1'b0;
            r_ldm   <= 1'b0;
            r_stm   <= 1'b0;
            r_bf    <= !dwbm_ack_i;
          end
        end
      endcase
    end
  end

  assign stall_o           = w_bus;
  assign valid_o           = r_valid;
  assign pc_o              = r_pc;
  assign instruction_o     = r_ins;
  assign alu_d_o           = r_alu;
  assign mem_d_o           = r_memd;
  assign mem_addr_o        = r_maddr;
  assign e_illegal_inst_o  = r_ill;
  assign e_inst_addr_mis_o = r_iam;
  assign e_ld_addr_mis_o   = r_ldm;
  assign e_st_addr_mis_o   = r_stm;
  assign e_bus_fault_o     = r_bf;
  assign dwbm_addr_o       = r_waddr;
  assign dwbm_dat_o        = r_wdat;
  assign dwbm_sel_o        = r_sel;
  assign dwbm_we_o         = r_we;
  assign dwbm_cyc_o        = r_cyc;
  assign dwbm_stb_o        = r_cyc;

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed vectors for stage_mem plus hand sequences
// for flush, reset mid-bus, back-to-back accept and the watchdog.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i, flush_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, st_data_i;
  logic [2:0]  funct3_i;
  logic        is_ld_mem_i, is_st_mem_i;
  logic        e_illegal_inst_i, e_inst_addr_mis_i;
  logic        stall_o, valid_o;
  logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
  logic        e_illegal_inst_o, e_inst_addr_mis_o;
  logic        e_ld_addr_mis_o, e_st_addr_mis_o, e_bus_fault_o;
  logic [31:0] dwbm_addr_o, dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o, dwbm_cyc_o, dwbm_stb_o;
  logic [31:0] dwbm_dat_i;
  logic        dwbm_ack_i;

  always #5 clk = ~clk;

  stage_mem #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .valid_i(valid_i), .flush_i(flush_i),
    .pc_i(pc_i), .instruction_i(instruction_i),
    .alu_d_i(alu_d_i), .st_data_i(st_data_i),
    .funct3_i(funct3_i),
    .is_ld_mem_i(is_ld_mem_i), .is_st_mem_i(is_st_mem_i),
    .e_illegal_inst_i(e_illegal_inst_i),
    .e_inst_addr_mis_i(e_inst_addr_mis_i),
    .stall_o(stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .instruction_o(instruction_o),
    .alu_d_o(alu_d_o), .mem_d_o(mem_d_o),
    .mem_addr_o(mem_addr_o),
    .e_illegal_inst_o(e_illegal_inst_o),
    .e_inst_addr_mis_o(e_inst_addr_mis_o),
    .e_ld_addr_mis_o(e_ld_addr_mis_o),
    .e_st_addr_mis_o(e_st_addr_mis_o),
    .e_bus_fault_o(e_bus_fault_o),
    .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o),
    .dwbm_sel_o(dwbm_sel_o), .dwbm_we_o(dwbm_we_o),
    .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o),
    .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    valid_i = 0; flush_i = 0;
    is_ld_mem_i = 0; is_st_mem_i = 0;
    e_illegal_inst_i = 0; e_inst_addr_mis_i = 0;
  endtask

  task automatic put(input logic ld, input logic st,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] sd);
    valid_i = 1; is_ld_mem_i = ld; is_st_mem_i = st;
    funct3_i = f3; alu_d_i = a; st_data_i = sd;
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          waits;
    logic        bus;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] memd;
    logic        ldm;
    logic        stm;
  } vec_t;

  vec_t v[14];

  task automatic run_vec(input vec_t t, input int idx);
    pc_i = 32'h100 + 32'(idx * 4);
    instruction_i = 32'hA000_0000 | 32'(idx);
    put(t.ld, t.st, t.f3, t.addr, t.sd);
    tick;
    idle_in;
    if (t.bus) begin
      chk("cyc", dwbm_cyc_o, 1);
      chk("stb", dwbm_stb_o, 1);
      chk("sel", dwbm_sel_o, t.sel);
      chk("we", dwbm_we_o, t.st);
      chk("adr", dwbm_addr_o, {t.addr[31:2], 2'b00});
      if (t.st) chk("dat_o", dwbm_dat_o, t.wdat);
      chk("bus_vld", valid_o, 0);
      for (int w = 0; w < t.waits; w++) begin
        chk("wait_stall", stall_o, 1);
        tick;
        chk("wait_cyc", dwbm_cyc_o, 1);
      end
      chk("stall", stall_o, 1);
      dwbm_ack_i = 1; dwbm_dat_i = t.rd;
      tick;
      dwbm_ack_i = 0; dwbm_dat_i = 0;
      chk("end_cyc", dwbm_cyc_o, 0);
      chk("end_stall", stall_o, 0);
    end else begin
      chk("nobus_cyc", dwbm_cyc_o, 0);
      chk("nobus_stall", stall_o, 0);
    end
    chk("valid", valid_o, 1);
    chk("mem_d", mem_d_o, t.memd);
    chk("mem_addr", mem_addr_o, t.addr);
    chk("pc", pc_o, 32'h100 + 32'(idx * 4));
    chk("ins", instruction_o, 32'hA000_0000 | 32'(idx));
    chk("alu", alu_d_o, t.addr);
    chk("ldm", e_ld_addr_mis_o, t.ldm);
    chk("stm", e_st_addr_mis_o, t.stm);
    chk("bf", e_bus_fault_o, 0);
    tick;
    chk("vld_pulse", valid_o, 0);
  endtask

  initial begin
    rst_i = 0; idle_in;
    pc_i = 0; instruction_i = 0; alu_d_i = 0;
    st_data_i = 0; funct3_i = 0;
    dwbm_dat_i = 0; dwbm_ack_i = 0;

    //           ld st f3  addr          sd            rd            w bus sel     wdat          memd          ldm stm
    v[0]  = '{1, 0, F3_LW,  32'h1000, 32'h0,        32'hDEADBEEF, 2, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0};
    v[1]  = '{1, 0, F3_LB,  32'h1003, 32'h0,        32'h80FF0000, 0, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0};
    v[2]  = '{1, 0, F3_LBU, 32'h1003, 32'h0,        32'h80FF0000, 0, 1, 4'b1000, 32'h0,        32'h00000080, 0, 0};
    v[3]  = '{0, 1, F3_SH,  32'h2002, 32'h1234ABCD, 32'h0,        1, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0};
    v[4]  = '{1, 0, F3_LH,  32'h1002, 32'h0,        32'h80011234, 0, 1, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0};
    v[5]  = '{1, 0, F3_LHU, 32'h1000, 32'h0,        32'h8001F234, 1, 1, 4'b0011, 32'h0,        32'h0000F234, 0, 0};
    v[6]  = '{0, 1, F3_SB,  32'h3001, 32'h000000A5, 32'h0,        0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0};
    v[7]  = '{0, 1, F3_SW,  32'h3000, 32'hCAFEF00D, 32'h0,        0, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0};
    v[8]  = '{1, 0, F3_LW,  32'h1002, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 0};
    v[9]  = '{0, 1, F3_SW,  32'h1001, 32'h55,       32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 1};
    v[10] = '{1, 0, F3_LH,  32'h1001, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 0};
    v[11] = '{1, 0, F3_LB,  32'h1001, 32'h0,        32'h00007F00, 0, 1, 4'b0010, 32'h0,        32'h0000007F, 0, 0};
    v[12] = '{0, 0, 3'd0,   32'h0055, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 0};
    v[13] = '{1, 0, 3'd3,   32'h2000, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 0};

    #12;
    chk("rst_cyc", dwbm_cyc_o, 0);
    chk("rst_stb", dwbm_stb_o, 0);
    chk("rst_vld", valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_sel", dwbm_sel_o, 0);
    rst_i = 1;
    tick;

    for (int i = 0; i < 14; i++) run_vec(v[i], i);

    // flush arriving mid-bus: cycle completes, result dropped
    put(1, 0, F3_LW, 32'h1000, 0);
    tick;
    idle_in;
    flush_i = 1;
    tick;
    flush_i = 0;
    chk("fl_cyc", dwbm_cyc_o, 1);
    dwbm_ack_i = 1; dwbm_dat_i = 32'h11112222;
    tick;
    dwbm_ack_i = 0;
    chk("fl_end_cyc", dwbm_cyc_o, 0);
    chk("fl_vld", valid_o, 0);
    chk("fl_stall", stall_o, 0);
    tick;

    // flush on accept: no bus, no valid
    put(1, 0, F3_LW, 32'h1000, 0);
    flush_i = 1;
    tick;
    idle_in;
    chk("fla_cyc", dwbm_cyc_o, 0);
    chk("fla_vld", valid_o, 0);
    tick;

    // upstream exception: passed through, no bus access
    put(1, 0, F3_LW, 32'h1000, 0);
    e_illegal_inst_i = 1;
    tick;
    idle_in;
    chk("exc_cyc", dwbm_cyc_o, 0);
    chk("exc_vld", valid_o, 1);
    chk("exc_ill", e_illegal_inst_o, 1);
    tick;

    // valid held high: no back-to-back bus cycles
    put(1, 0, F3_LW, 32'h1000, 0);
    tick;
    dwbm_ack_i = 1; dwbm_dat_i = 32'h0BADF00D;
    tick;
    dwbm_ack_i = 0;
    chk("b2b_gap_cyc", dwbm_cyc_o, 0);
    chk("b2b_vld", valid_o, 1);
    chk("b2b_md", mem_d_o, 32'h0BADF00D);
    tick;
    idle_in;
    chk("b2b_cyc2", dwbm_cyc_o, 1);
    dwbm_ack_i = 1;
    tick;
    dwbm_ack_i = 0;
    chk("b2b_done", dwbm_cyc_o, 0);
    tick;

    // reset mid-bus drops cyc/stb at once
    put(0, 1, F3_SW, 32'h4000, 32'h12345678);
    tick;
    idle_in;
    chk("rb_cyc", dwbm_cyc_o, 1);
    #2;
    rst_i = 0;
    #1;
    chk("rb_cyc0", dwbm_cyc_o, 0);
    chk("rb_stb0", dwbm_stb_o, 0);
    chk("rb_stall0", stall_o, 0);
    @(negedge clk);
    rst_i = 1;
    tick;
    chk("rb_idle", dwbm_cyc_o, 0);

`ifdef MEM_BUS_TIMEOUT_EN
    // no ack: abort after 4 bus cycles
    put(1, 0, F3_LW, 32'h1000, 0);
    tick;
    idle_in;
    for (int k = 0; k < 3; k++) begin
      chk("to_wait_cyc", dwbm_cyc_o, 1);
      tick;
    end
    chk("to_last_cyc", dwbm_cyc_o, 1);
    tick;
    chk("to_cyc", dwbm_cyc_o, 0);
    chk("to_bf", e_bus_fault_o, 1);
    chk("to_vld", valid_o, 1);
    chk("to_md", mem_d_o, 0);
    tick;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
Memory-access pipeline stage between execute and write-back. Performs loads and stores over a Wishbone-classic data master port and detects load/store address misalignment. Aligns and sign-extends load data. Registers the full result bundle (pc, instruction, ALU result, load data, memory address, exception flags) into the write-back stage. Stalls upstream while a bus cycle is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; used only when MEM_BUS_TIMEOUT_EN is defined.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
valid_i  in  1  execute stage presents a valid instruction
flush_i  in  1  kill the instruction being accepted or in flight
pc_i  in  32  instruction PC
instruction_i  in  32  raw instruction
alu_d_i  in  32  ALU result; byte address for loads and stores
st_data_i  in  32  store data (rs2)
funct3_i  in  3  width/sign selector
is_ld_mem_i  in  1  load
is_st_mem_i  in  1  store
e_illegal_inst_i  in  1  upstream exception, passed through
e_inst_addr_mis_i  in  1  upstream exception, passed through
stall_o  out  1  upstream must hold its outputs
valid_o  out  1  write-back bundle valid
pc_o, instruction_o, alu_d_o  out  32 each  registered pass-through
mem_d_o  out  32  aligned load data
mem_addr_o  out  32  registered byte address
e_illegal_inst_o, e_inst_addr_mis_o  out  1 each  registered pass-through
e_ld_addr_mis_o, e_st_addr_mis_o  out  1 each  misalignment flags
e_bus_fault_o  out  1  bus watchdog expiry
dwbm_addr_o  out  32  word address {addr[31:2],2'b00}
dwbm_dat_o  out  32  store data
dwbm_sel_o  out  4  byte lanes
dwbm_we_o, dwbm_cyc_o, dwbm_stb_o  out  1 each  Wishbone control
dwbm_dat_i  in  32  read data
dwbm_ack_i  in  1  transfer acknowledge

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE. All outputs are 0, including cyc, stb and valid_o.
- FSM states: IDLE and BUS.
- stall_o = (state==BUS). Combinational.
- Accept condition: valid_i && state==IDLE.
- Misalignment is checked on accept:
  - LH/LHU/SH: fault when addr[0]=1.
  - LW/SW: fault when addr[1:0]≠0.
  - Byte accesses never fault.
  - A misaligned access raises e_ld_addr_mis_o or e_st_addr_mis_o and issues no bus access.
- No bus access when any incoming exception is set, or when flush_i=1.
- Non-memory, faulting or flushed accept: registers the bundle at the next edge (latency 1). valid_o = !flush_i. mem_d_o=0.
- Aligned memory accept:
  - Next edge: state→BUS; cyc=stb=1; we=is_st_mem_i.
  - SB: sel = 0001<<addr[1:0]; dat = {4{b}}.
  - SH: sel = 0011<<addr[1:0]; dat = {2{h}}.
  - SW: sel = 1111; dat = word.
  - Bundle fields are captured into holding registers. valid_o=0 while in BUS.
- BUS with dwbm_ack_i=1 at an edge:
  - cyc/stb drop at that edge; state→IDLE.
  - valid_o=1 with load data aligned:
    - LB/LBU: byte addr[1:0], sign- or zero-extended.
    - LH/LHU: half addr[1], sign- or zero-extended.
    - LW: full word.
  - Minimum load/store latency is 2 cycles, plus wait states.
- flush_i during BUS: the transaction still completes (no abort); on ack, valid_o=0.
- Next instruction: accepted in the cycle after return to IDLE. No back-to-back bus cycles.
- Reset mid-BUS: cyc/stb drop immediately; the transaction is discarded.
- funct3 values 3/6/7 on a load, or 3–7 on a store: no bus access. The upstream decoder already flags these as illegal.

Optional Feature:
MEM_BUS_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When count==TIMEOUT_CYCLES: drop cyc/stb, state→IDLE, valid_o=1 (unless flushed), e_bus_fault_o=1, mem_d_o=0.
  - An ack in the same cycle wins.
- Undefined: no counter; e_bus_fault_o tied 0; BUS waits indefinitely.

Decomposition:
- Shared package/header: funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2), FSM state encodings, Wishbone sel constants.
- One sub-module, mem_load_align: combinational (dat_i, funct3, addr[1:0]) → aligned 32-bit word. Reused by the instruction-side unit.

Test Plan:
- LW at 0x1000, ack after 2 waits, dat_i=0xDEADBEEF → stall_o high 3 cycles; sel=1111; mem_d_o=0xDEADBEEF; valid_o for 1 cycle.
- LB at 0x1003, dat_i=0x80FF_0000 → sel=1000; mem_d_o=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH at 0x2002, st_data=0x1234ABCD → we=1; sel=1100; dat_o=0xABCDABCD.
- LW at 0x1002 → no cyc; next cycle e_ld_addr_mis_o=1, mem_addr_o=0x1002, valid_o=1. SW at 0x1001 → e_st_addr_mis_o=1.
- flush_i mid-BUS, ack arrives → cycle completes, valid_o stays 0. rst_i low mid-BUS → cyc/stb 0 immediately.
- With MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → abort after 4 BUS cycles, e_bus_fault_o=1.
